// File: rtl/sodor_lb_divergence_monitor.sv
// Divergence monitor for the two-copy Sodor miter: compares both cores' load-buffer
// table ports each cycle, latches the first divergence and issues one registered verdict.
module sodor_lb_divergence_monitor #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 5,
  parameter int ARM_CYCLE   = 2,
  parameter int CHECK_CYCLE = 18,
  parameter int CHECK_DATA  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pre_eq,
  input  logic             lb_valid1,
  input  logic [XLEN-1:0]  lb_addr1,
  input  logic [XLEN-1:0]  lb_data1,
  input  logic             lb_valid2,
  input  logic [XLEN-1:0]  lb_addr2,
  input  logic [XLEN-1:0]  lb_data2,
  output logic [CNT_W-1:0] cycle,
  output logic             observing,
  output logic             div_seen,
  output logic [1:0]       div_kind,
  output logic [CNT_W-1:0] div_cycle,
  output logic             done,
  output logic             fail,
  output logic             vacuous
);

  typedef enum logic [1:0] {IDLE, OBSERVE, DONE, VACUOUS} state_t;

  localparam logic [CNT_W-1:0] ARM_C = CNT_W'(ARM_CYCLE);
  localparam logic [CNT_W-1:0] CHK_C = CNT_W'(CHECK_CYCLE);
  localparam logic [CNT_W-1:0] MAX_C = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_div_cycle;
  logic [1:0]       r_div_kind;
  logic             r_observing;
  logic             r_div_seen;
  logic             r_done;
  logic             r_fail;
  logic             r_vacuous;

  logic             w_valid_x;
  logic             w_both;
  logic             w_addr_x;
  logic             w_data_x;
  logic [1:0]       w_kind;
  logic             w_d;

  assign w_valid_x = lb_valid1 ^ lb_valid2;
  assign w_both    = lb_valid1 & lb_valid2;
  assign w_addr_x  = w_both & (lb_addr1 != lb_addr2);
  assign w_data_x  = (CHECK_DATA != 0) & w_both & (lb_data1 != lb_data2);

  // Priority valid > addr > data; addr/data are meaningless unless both sides are valid.
  always_comb begin
    w_kind = 2'd0;
    if (w_valid_x)     w_kind = 2'd1;
    else if (w_addr_x) w_kind = 2'd2;
    else if (w_data_x) w_kind = 2'd3;
  end

  assign w_d = (w_kind != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cycle     <= '0;
      r_div_cycle <= '0;
      r_div_kind  <= 2'd0;
      r_observing <= 1'b0;
      r_div_seen  <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_vacuous   <= 1'b0;
    end else begin
      if (r_cycle != MAX_C) r_cycle <= r_cycle + 1'b1;
      case (r_state)
        IDLE: begin
          if (r_cycle == ARM_C) begin
            if (pre_eq) begin
              r_state     <= OBSERVE;
              r_observing <= 1'b1;
              // The arming sample itself already lies inside the observation window.
              if (w_d) begin
                r_div_seen  <= 1'b1;
                r_div_kind  <= w_kind;
                r_div_cycle <= r_cycle;
              end
            end else begin
              r_state   <= VACUOUS;
              r_done    <= 1'b1;
              r_vacuous <= 1'b1;
            end
          end
        end
        OBSERVE: begin
          if (w_d && !r_div_seen) begin
            r_div_seen  <= 1'b1;
            r_div_kind  <= w_kind;
            r_div_cycle <= r_cycle;
          end
          if (r_cycle == CHK_C) begin
            r_state     <= DONE;
            r_observing <= 1'b0;
            r_done      <= 1'b1;
            r_fail      <= r_div_seen | w_d;
          end
        end
        DONE:    r_state <= DONE;
        VACUOUS: r_state <= VACUOUS;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cycle     = r_cycle;
  assign observing = r_observing;
  assign div_seen  = r_div_seen;
  assign div_kind  = r_div_kind;
  assign div_cycle = r_div_cycle;
  assign done      = r_done;
  assign fail      = r_fail;
  assign vacuous   = r_vacuous;

`ifdef FORMAL
  always @(posedge clk) begin
    if (!reset) assert (!(r_done & r_fail));
  end
`endif

endmodule
